// File: rtl/alu_pkg.sv
// Shared decode constants and operation-select encoding for the sequential ALU.
package alu_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_LB    = 6'b100000;
  localparam logic [OPC_W-1:0] OPC_SB    = 6'b101000;
  localparam logic [OPC_W-1:0] OPC_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OPC_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OPC_XORI  = 6'b001110;
  localparam logic [OPC_W-1:0] OPC_SLTI  = 6'b001010;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_BNE   = 6'b000101;

  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 6'b000011;
  localparam logic [FUNCT_W-1:0] FN_SLLV = 6'b000100;
  localparam logic [FUNCT_W-1:0] FN_SRLV = 6'b000110;
  localparam logic [FUNCT_W-1:0] FN_SRAV = 6'b000111;

  typedef enum logic [3:0] {
    OP_AND     = 4'd0,
    OP_OR      = 4'd1,
    OP_ADD     = 4'd2,
    OP_SUB     = 4'd3,
    OP_SLT     = 4'd4,
    OP_SLL     = 4'd5,
    OP_SRL     = 4'd6,
    OP_SRA     = 4'd7,
    OP_XOR     = 4'd8,
    OP_NOR     = 4'd9,
    OP_ILLEGAL = 4'd15
  } alu_op_e;

  // Variable shifts take their amount from src_a instead of shamt.
  function automatic logic is_var_shift(input logic [FUNCT_W-1:0] funct);
    return (funct == FN_SLLV) || (funct == FN_SRLV) || (funct == FN_SRAV);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decode into an ALU operation select.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  output alu_op_e            sel,
  output logic               is_shift,
  output logic               is_var
);

  always_comb begin
    sel      = OP_ILLEGAL;
    is_shift = 1'b0;
    is_var   = 1'b0;
    if (opcode == OPC_RTYPE) begin
      case (funct)
        FN_ADD:           sel = OP_ADD;
        FN_SUB:           sel = OP_SUB;
        FN_AND:           sel = OP_AND;
        FN_OR:            sel = OP_OR;
        FN_XOR:           sel = OP_XOR;
        FN_NOR:           sel = OP_NOR;
        FN_SLT:           sel = OP_SLT;
        FN_SLL, FN_SLLV: begin sel = OP_SLL; is_shift = 1'b1; end
        FN_SRL, FN_SRLV: begin sel = OP_SRL; is_shift = 1'b1; end
        FN_SRA, FN_SRAV: begin sel = OP_SRA; is_shift = 1'b1; end
        default:          sel = OP_ILLEGAL;
      endcase
      is_var = is_shift && is_var_shift(funct);
    end else begin
      case (opcode)
        OPC_ADDI, OPC_LW, OPC_SW, OPC_LB, OPC_SB: sel = OP_ADD;
        OPC_ANDI:           sel = OP_AND;
        OPC_ORI:            sel = OP_OR;
        OPC_XORI:           sel = OP_XOR;
        OPC_SLTI:           sel = OP_SLT;
        OPC_BEQ, OPC_BNE:   sel = OP_SUB;
        default:            sel = OP_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle logic/arith ops plus a bit-serial shifter.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [WIDTH-1:0]   r_result, w_result_nxt;
  logic [SHAMT_W-1:0] r_count, w_count_nxt;
  alu_op_e            r_shift_op, w_shift_op_nxt;
  logic               r_zero, w_zero_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_ill, w_ill_nxt;
  logic               r_out_valid, w_out_valid_nxt;

  alu_op_e            w_sel;
  logic               w_is_shift;
  logic               w_is_var;
  logic               w_accept;
  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH-1:0]   w_sum;
  logic               w_add_ovf;
  logic               w_lt;
  logic [WIDTH-1:0]   w_alu_res;
  logic [WIDTH-1:0]   w_single_res;
  logic [SHAMT_W-1:0] w_amount;
  logic [WIDTH-1:0]   w_acc_step;

  alu_op_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .sel      (w_sel),
    .is_shift (w_is_shift),
    .is_var   (w_is_var)
  );

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign illegal   = r_ill;

  // Shared adder: SUB adds the two's-complement negation of src_b.
  assign w_b_eff   = (w_sel == OP_SUB) ? (~src_b + WIDTH'(1)) : src_b;
  assign w_sum     = src_a + w_b_eff;
  assign w_add_ovf = (src_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != src_a[WIDTH-1]);
  assign w_lt      = $signed(src_a) < $signed(src_b);
  assign w_amount  = w_is_var ? src_a[SHAMT_W-1:0] : shamt;

  always_comb begin
    w_alu_res = '0;
    case (w_sel)
      OP_ADD, OP_SUB: w_alu_res = w_sum;
      OP_AND:         w_alu_res = src_a & src_b;
      OP_OR:          w_alu_res = src_a | src_b;
      OP_XOR:         w_alu_res = src_a ^ src_b;
      OP_NOR:         w_alu_res = ~(src_a | src_b);
      OP_SLT:         w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
      default:        w_alu_res = '0;
    endcase
  end

  // A zero-amount shift completes immediately with src_b unchanged.
  assign w_single_res = w_is_shift ? src_b : w_alu_res;

  always_comb begin
    w_acc_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    case (r_shift_op)
      OP_SLL:  w_acc_step = {r_acc[WIDTH-2:0], 1'b0};
      OP_SRL:  w_acc_step = {1'b0, r_acc[WIDTH-1:1]};
      default: w_acc_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_result_nxt    = r_result;
    w_count_nxt     = r_count;
    w_shift_op_nxt  = r_shift_op;
    w_zero_nxt      = r_zero;
    w_ovf_nxt       = r_ovf;
    w_ill_nxt       = r_ill;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_shift && (w_amount != '0)) begin
            w_acc_nxt      = src_b;
            w_count_nxt    = w_amount;
            w_shift_op_nxt = w_sel;
            w_state_nxt    = ST_SHIFT;
          end else begin
            w_result_nxt    = w_single_res;
            w_zero_nxt      = (w_single_res == '0);
            w_ovf_nxt       = ((w_sel == OP_ADD) || (w_sel == OP_SUB)) && w_add_ovf;
            w_ill_nxt       = (w_sel == OP_ILLEGAL);
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        w_acc_nxt   = w_acc_step;
        w_count_nxt = r_count - SHAMT_W'(1);
        if (r_count == SHAMT_W'(1)) begin
          w_result_nxt    = w_acc_step;
          w_zero_nxt      = (w_acc_step == '0);
          w_ovf_nxt       = 1'b0;
          w_ill_nxt       = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_result    <= '0;
      r_count     <= '0;
      r_shift_op  <= OP_SLL;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_result    <= w_result_nxt;
      r_count     <= w_count_nxt;
      r_shift_op  <= w_shift_op_nxt;
      r_zero      <= w_zero_nxt;
      r_ovf       <= w_ovf_nxt;
      r_ill       <= w_ill_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, handshaked ALU execution unit for the MIPS datapath.
- Decodes opcode/funct into an internal operation select and executes it.
- Single-cycle ops: registered result, 1-cycle latency.
- Shifts: serial, one bit per cycle, so no wide barrel shifter.
- Sits between decode/register-read and writeback. Extends the existing ALU op set with XOR/NOR/XORI, variable shifts, flags and an illegal-op indication.

Parameters:
- WIDTH, 32, datapath width in bits (power of two, ≥8).
- SHAMT_W, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- opcode  in  6  instruction opcode (000000 = R-type).
- funct  in  6  R-type function field; ignored otherwise.
- src_a  in  WIDTH  rs operand; low SHAMT_W bits are the variable shift amount.
- src_b  in  WIDTH  rt operand, or immediate already extended upstream.
- shamt  in  SHAMT_W  constant shift amount.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow on ADD/SUB.
- illegal  out  1  undecoded opcode/funct.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - rst=1 at any edge, including mid-shift or while holding a result, forces IDLE with out_valid=0, result=0, zero=0, overflow=0, illegal=0, count=0. The in-flight op is discarded.
- Decode, R-type by funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
  - 000000 SLL, 000010 SRL, 000011 SRA: amount = shamt.
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: amount = src_a[SHAMT_W-1:0].
- Decode, other opcodes:
  - ADD: 001000 addi, 100011 lw, 101011 sw, 100000 lb, 101000 sb.
  - AND: 001100 andi. OR: 001101 ori. XOR: 001110 xori. SLT: 001010 slti.
  - SUB: 000100 beq, 000101 bne.
  - Anything else: ILLEGAL.
- Shift direction: all shifts operate on src_b.
- FSM states: IDLE, SHIFT, DONE.
- Handshake:
  - in_ready = (state==IDLE) && !rst. Accept = in_valid && in_ready.
  - No accept is possible while in SHIFT or DONE.
- Single-cycle ops (ADD/SUB/AND/OR/XOR/NOR/SLT/ILLEGAL):
  - On accept, register result and flags; next state DONE.
  - out_valid rises the edge after accept (latency 1).
- ILLEGAL: result=0, zero=1, illegal=1, overflow=0.
- Shifts, on accept:
  - Amount n=0: result=src_b, go DONE (latency 1).
  - Amount n≥1: acc=src_b, count=n, go SHIFT.
  - In SHIFT, each edge shifts acc by 1 (SRA replicates the MSB) and decrements count. The edge where count==1 does the last shift and enters DONE.
  - out_valid after exactly n edges. n=WIDTH-1 is the maximum.
- Arithmetic and flags:
  - Arithmetic is WIDTH-bit two's complement, with wrap-around on ADD/SUB.
  - overflow = sign(a)==sign(b') && sign(res)!=sign(a), where b'=b for ADD and ~b+1 for SUB.
  - overflow=0 for non-ADD/SUB ops.
  - SLT is signed; result = {WIDTH-1 zeros, lt}.
  - zero is computed from the final result for every op.
- DONE:
  - out_valid=1; result and flags held stable until out_valid && out_ready.
  - On that edge: out_valid=0, state IDLE.
  - in_ready rises the following cycle, so back-to-back throughput is one op per 2 cycles minimum.
- Simultaneous events: rst has priority over handshake. in_valid during SHIFT/DONE is ignored and must be held by the producer.

Decomposition:
- Package alu_pkg:
  - opcode and funct localparams.
  - 4-bit op-select enum: AND=0, OR=1, ADD=2, SUB=3, SLT=4, SLL=5, SRL=6, SRA=7, XOR=8, NOR=9, ILLEGAL=15.
  - Flag that marks variable-shift ops.
- Sub-module alu_op_decode: combinational. Inputs opcode, funct. Outputs sel, is_shift, is_var.
- FSM, single-cycle datapath and serial shifter stay in alu_seq_unit.

Test Plan:
- Reset, then addi with src_a=0x7FFFFFFF, src_b=1, out_ready=1 -> out_valid one cycle after accept, result=0x80000000, overflow=1, zero=0.
- beq with src_a=src_b=0x1234 -> result=0, zero=1, overflow=0. slti with a=0xFFFFFFFF, b=0 -> result=1.
- SRA with src_b=0x80000000, shamt=31 -> in_ready low for 31 cycles, out_valid on the 31st edge, result=0xFFFFFFFF. SLL with shamt=0, src_b=0xA5 -> result=0xA5 after 1 cycle.
- SRLV with src_a=0x24 (amount 4), src_b=0xF0 -> result=0x0F. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0, new in_valid ignored.
- R-type funct=111111 -> illegal=1, result=0, zero=1. opcode=000010 (j) -> illegal=1.
- SLL by 20 started, rst asserted at shift cycle 10 -> next cycle out_valid=0, result=0, in_ready=1. A fresh ADD 3+4 then yields 7.
